// File: rtl/rr_mux_arbiter.sv
// Round-robin N:1 arbiter with a registered valid/ready output stage.
// One word is captured per IDLE arbitration and held until the downstream accepts it.
module rr_mux_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   gnt,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_src
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_ptr;
    logic            w_found;
    logic [SW-1:0]   w_win;
    logic [SW:0]     w_idx;
    logic            w_capture;
    logic            w_xfer;

    // Rotating search starting at r_ptr; the extra index bit absorbs ptr+i before the wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, r_ptr} + (SW+1)'(i);
            if (w_idx >= (SW+1)'(N)) begin
                w_idx = w_idx - (SW+1)'(N);
            end
            if (!w_found && req[w_idx[SW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)   w_state_nxt = S_BUSY;
            S_BUSY:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_capture = (r_state == S_IDLE) && w_found;
        w_xfer    = (r_state == S_BUSY) && out_ready;
    end

    // ptr moves only when a word leaves, so a stalled grant never shifts priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            r_ptr     <= '0;
        end else begin
            gnt <= '0;
            if (w_capture) begin
                out_data  <= data[w_win*W +: W];
                out_src   <= w_win;
                gnt       <= {{(N-1){1'b0}}, 1'b1} << w_win;
                out_valid <= 1'b1;
            end else if (w_xfer) begin
                out_valid <= 1'b0;
                r_ptr     <= (out_src == SW'(N-1)) ? '0 : out_src + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (N=4, W=8): reset, rotation, backpressure, wrap, async reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_rr_mux_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_src;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n     = 1'b0;
        req       = 4'($urandom);
        data      = $urandom;
        out_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (gnt !== 4'b0000)    begin bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
        total++; if (out_src !== 2'd0)   begin bad++; $display("FAIL rst_src got=%0d exp=0", out_src); end
        req       = 4'b0000;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_valid got=%b exp=0", out_valid); end
        total++; if (gnt !== 4'b0000)    begin bad++; $display("FAIL rel_gnt got=%b exp=0000", gnt); end
        total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rel_data got=%h exp=00", out_data); end
    endtask

    // ptr starts at 0; all four requesting -> 0,1,2,3,0,1, ends with ptr=2.
    task automatic test_fairness();
        logic [1:0] exp_src [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp_dat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        data      = 32'h4433_2211;
        out_ready = 1'b1;
        req       = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            total++; if (gnt !== (4'b0001 << exp_src[n])) begin bad++; $display("FAIL fair_gnt[%0d] got=%b exp_src=%0d", n, gnt, exp_src[n]); end
            total++; if (out_src !== exp_src[n])          begin bad++; $display("FAIL fair_src[%0d] got=%0d exp=%0d", n, out_src, exp_src[n]); end
            total++; if (out_data !== exp_dat[exp_src[n]]) begin bad++; $display("FAIL fair_data[%0d] got=%h exp=%h", n, out_data, exp_dat[exp_src[n]]); end
            total++; if (out_valid !== 1'b1)              begin bad++; $display("FAIL fair_valid[%0d] got=%b exp=1", n, out_valid); end
            @(negedge clk);
            total++; if (out_valid !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL fair_gap[%0d] got valid=%b gnt=%b exp valid=0 gnt=0000", n, out_valid, gnt); end
        end
        req = 4'b0000;
    endtask

    // ptr=2: single request from 2, ends with ptr=3.
    task automatic test_single();
        data      = 32'h00A5_0000;
        out_ready = 1'b1;
        req       = 4'b0100;
        @(negedge clk);
        total++; if (gnt !== 4'b0100)    begin bad++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h exp=a5", out_data); end
        total++; if (out_src !== 2'd2)   begin bad++; $display("FAIL single_src got=%0d exp=2", out_src); end
        req = 4'b0000;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_done_valid got=%b exp=0", out_valid); end
        total++; if (gnt !== 4'b0000)    begin bad++; $display("FAIL single_done_gnt got=%b exp=0000", gnt); end
    endtask

    // ptr=3: req 0011 wraps to 0, then 1; ends with ptr=2.
    task automatic test_wrap_skip();
        data      = 32'h0000_6655;
        out_ready = 1'b1;
        req       = 4'b0011;
        @(negedge clk);
        total++; if (gnt !== 4'b0001 || out_src !== 2'd0) begin bad++; $display("FAIL wrap_first got gnt=%b src=%0d exp gnt=0001 src=0", gnt, out_src); end
        total++; if (out_data !== 8'h55) begin bad++; $display("FAIL wrap_first_data got=%h exp=55", out_data); end
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 4'b0010 || out_src !== 2'd1) begin bad++; $display("FAIL wrap_second got gnt=%b src=%0d exp gnt=0010 src=1", gnt, out_src); end
        total++; if (out_data !== 8'h66) begin bad++; $display("FAIL wrap_second_data got=%h exp=66", out_data); end
        req = 4'b0000;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wrap_done_valid got=%b exp=0", out_valid); end
    endtask

    // ptr=2: grant 1, stall 5 cycles, then req 1111 must go to 2; ends with ptr=3.
    task automatic test_backpressure();
        data      = 32'hDDCC_BBAA;
        out_ready = 1'b0;
        req       = 4'b0010;
        @(negedge clk);
        total++; if (gnt !== 4'b0010 || out_src !== 2'd1) begin bad++; $display("FAIL bp_grant got gnt=%b src=%0d exp gnt=0010 src=1", gnt, out_src); end
        total++; if (out_data !== 8'hBB) begin bad++; $display("FAIL bp_grant_data got=%h exp=bb", out_data); end
        for (int n = 0; n < 5; n++) begin
            req  = (n % 2 == 0) ? 4'b1101 : 4'b1111;
            data = ~data;
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || gnt !== 4'b0000) begin bad++; $display("FAIL bp_hold[%0d] got valid=%b gnt=%b exp valid=1 gnt=0000", n, out_valid, gnt); end
            total++; if (out_data !== 8'hBB || out_src !== 2'd1) begin bad++; $display("FAIL bp_frozen[%0d] got data=%h src=%0d exp data=bb src=1", n, out_data, out_src); end
        end
        data      = 32'h4433_2211;
        req       = 4'b1111;
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        total++; if (gnt !== 4'b0100 || out_src !== 2'd2) begin bad++; $display("FAIL bp_next got gnt=%b src=%0d exp gnt=0100 src=2", gnt, out_src); end
        total++; if (out_data !== 8'h33) begin bad++; $display("FAIL bp_next_data got=%h exp=33", out_data); end
        req = 4'b0000;
        @(negedge clk);
    endtask

    // ptr=3: capture 3, reset between edges, then ptr must be back at 0.
    task automatic test_async_reset();
        data      = 32'h7700_0088;
        out_ready = 1'b0;
        req       = 4'b1000;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_src !== 2'd3) begin bad++; $display("FAIL ar_capture got valid=%b src=%0d exp valid=1 src=3", out_valid, out_src); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid_now got=%b exp=0", out_valid); end
        total++; if (out_data !== 8'h00 || out_src !== 2'd0 || gnt !== 4'b0000) begin bad++; $display("FAIL ar_clear got data=%h src=%0d gnt=%b exp 00/0/0000", out_data, out_src, gnt); end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        req       = 4'b1001;
        @(negedge clk);
        total++; if (gnt !== 4'b0001 || out_src !== 2'd0) begin bad++; $display("FAIL ar_ptr0 got gnt=%b src=%0d exp gnt=0001 src=0", gnt, out_src); end
        total++; if (out_data !== 8'h88) begin bad++; $display("FAIL ar_ptr0_data got=%h exp=88", out_data); end
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        total++; if (gnt !== 4'b1000 || out_src !== 2'd3) begin bad++; $display("FAIL ar_regrant got gnt=%b src=%0d exp gnt=1000 src=3", gnt, out_src); end
        total++; if (out_data !== 8'h77) begin bad++; $display("FAIL ar_regrant_data got=%h exp=77", out_data); end
        req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single();
        test_wrap_skip();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
